// File: rtl/cpu_axi_arbiter.sv
// Shares one AXI master port between instruction fetch and data memory.
// Data wins over fetch; one transaction outstanding; completion pulses in IDLE.
module cpu_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_data_ok,
  output logic              stallreq_from_if,
  output logic              stallreq_from_mem,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready,
  output logic [2:0]        state_dbg
);

  // Handshakes: a channel transfers on a cycle where its valid and ready are
  // both high; valid never depends combinationally on ready.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              owner_q;  // 1 = data requester, 0 = fetch
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_done;
  logic              w_done;
  logic              inst_elig;
  logic              data_elig;
  logic              grant_data;
  logic              grant_inst;

  // A requester still showing its completion pulse is holding a finished request.
  assign inst_elig = inst_req & ~inst_data_ok;
  assign data_elig = data_req & ~data_data_ok;

  always_comb begin
    state_nxt  = state;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    case (state)
      IDLE: begin
        if (data_elig) begin
          grant_data = 1'b1;
          state_nxt  = data_wr ? WR_ADDR : RD_ADDR;
        end else if (inst_elig) begin
          grant_inst = 1'b1;
          state_nxt  = RD_ADDR;
        end
      end
      RD_ADDR: if (arready) state_nxt = RD_DATA;
      RD_DATA: if (rvalid) state_nxt = IDLE;
      WR_ADDR: if ((aw_done | awready) & (w_done | wready)) state_nxt = WR_RESP;
      WR_RESP: if (bvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      if (grant_data) begin
        owner_q <= 1'b1;
        addr_q  <= data_addr;
        size_q  <= data_size;
        wdata_q <= data_wdata;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (grant_inst) begin
        owner_q <= 1'b0;
        addr_q  <= inst_addr;
        size_q  <= 2'd2;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == WR_ADDR) begin
        if (awvalid & awready) aw_done <= 1'b1;
        if (wvalid & wready)   w_done  <= 1'b1;
      end
      if (state == RD_DATA && rvalid) begin
        if (owner_q) begin
          data_rdata   <= rdata;
          data_data_ok <= 1'b1;
        end else begin
          inst_rdata   <= rdata;
          inst_data_ok <= 1'b1;
        end
      end
      if (state == WR_RESP && bvalid) data_data_ok <= 1'b1;
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = 4'b0011 << addr_q[1:0];
      default: wstrb = 4'b1111;
    endcase
  end

  assign stallreq_from_if  = inst_req & ~inst_data_ok;
  assign stallreq_from_mem = data_req & ~data_data_ok;

  assign arid      = {3'b000, owner_q};
  assign araddr    = addr_q;
  assign arsize    = {1'b0, size_q};
  assign arvalid   = (state == RD_ADDR);
  assign rready    = (state == RD_DATA);
  assign awaddr    = addr_q;
  assign awsize    = {1'b0, size_q};
  assign awvalid   = (state == WR_ADDR) & ~aw_done;
  assign wdata     = wdata_q;
  assign wvalid    = (state == WR_ADDR) & ~w_done;
  assign bready    = (state == WR_RESP);
  assign state_dbg = state;

endmodule

// File: doc/cpu_axi_arbiter.md
# cpu_axi_arbiter

Shares the CPU's single AXI master port between the instruction-fetch and data-memory requesters. It serialises their SRAM-like requests into one-outstanding AXI transactions, data before instruction. It returns read data and completion pulses to each requester, and drives the `stallreq_from_if` / `stallreq_from_mem` inputs of the hazard unit. It sits between the pipeline datapath and the SoC AXI interconnect.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; one word per AXI beat.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `inst_req`  in  1  fetch request; held until `inst_data_ok`.
- `inst_addr`  in  ADDR_W  fetch address, word aligned.
- `inst_rdata`  out  DATA_W  fetched word.
- `inst_data_ok`  out  1  one-cycle completion pulse.
- `data_req`  in  1  load/store request; held until `data_data_ok`.
- `data_wr`  in  1  1 = store.
- `data_size`  in  2  0 = byte, 1 = half, 2 = word.
- `data_addr`  in  ADDR_W  byte address, naturally aligned.
- `data_wdata`  in  DATA_W  store data, already lane-replicated.
- `data_rdata`  out  DATA_W  load word.
- `data_data_ok`  out  1  one-cycle completion pulse.
- `stallreq_from_if`  out  1  = `inst_req & ~inst_data_ok`.
- `stallreq_from_mem`  out  1  = `data_req & ~data_data_ok`.
- `arid`, `araddr`, `arsize`, `arvalid`  out  4/ADDR_W/3/1  read address channel.
- `arready`  in  1  read address channel ready.
- `rdata`, `rvalid`  in  DATA_W/1  read data channel.
- `rready`  out  1  read data channel ready.
- `awaddr`, `awsize`, `awvalid`  out  ADDR_W/3/1  write address channel.
- `awready`  in  1  write address channel ready.
- `wdata`, `wstrb`, `wvalid`  out  DATA_W/4/1  write data channel.
- `wready`  in  1  write data channel ready.
- `bvalid`  in  1  write response valid.
- `bready`  out  1  write response ready.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE grant rules:
  - If eligible `data_req` is high: go to WR_ADDR when `data_wr` = 1, else RD_ADDR; owner = DATA.
  - Else if eligible `inst_req` is high: go to RD_ADDR; owner = INST.
  - A requester whose `*_data_ok` is high this cycle is ineligible, so a held request is not re-granted.
- At grant, latch `addr`, `size`, `wdata` and owner. AXI outputs come only from the latched copies.
- `arid` = 0 for INST, 1 for DATA.
- `arsize` / `awsize` = {1'b0, size}; INST always uses size 2.
- `wstrb` encoding:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- RD_ADDR: `arvalid` = 1; on `arready`, go to RD_DATA.
- RD_DATA: `rready` = 1; on `rvalid`:
  - register `rdata` into the owner's `*_rdata`;
  - pulse the owner's `*_data_ok` the next cycle;
  - go to IDLE.
- WR_ADDR: `awvalid` and `wvalid` are raised together. Each drops independently after its own handshake; per-channel done flags are tracked. When both are done, go to WR_RESP.
- WR_RESP: `bready` = 1; on `bvalid`, pulse `data_data_ok` the next cycle and go to IDLE.
- `*_rdata` holds its value until that requester's next read completes. Writes leave `data_rdata` unchanged.
- Stall outputs are combinational. All other outputs are registered or decoded from state.

## Timing
- Reset values: state IDLE; all valid/ready outputs 0; `*_data_ok` 0; `*_rdata` 0; latched addr/size/wdata 0. Stalls then follow the request inputs.
- Reset mid-transaction: return to IDLE next cycle, drop all valids, no completion pulse. Outstanding bus state is not tracked; the SoC reset clears the interconnect.
- Minimum latency, request seen in IDLE at cycle 0, with zero-wait slave:
  - read: `arvalid` in cycle 1, `rready` in cycle 2, `data_ok` in cycle 3;
  - write: aw/w in cycle 1, `bready` in cycle 2, `data_ok` in cycle 3.
- `*_data_ok` is exactly one cycle wide. Its cycle is the IDLE cycle, so the next grant happens no earlier than that same cycle.
- Both requests raised in the same cycle: DATA is served first. INST is granted in the IDLE cycle where `data_data_ok` pulses, unless `data_req` is again high, eligible and new.
- `awready` and `wready` may arrive in either order or together; a `bvalid` before both handshakes complete is ignored.
- Only one AXI transaction is outstanding at a time. No bursts; all lengths are 1.

## Test plan
- Reset then idle: assert `rst` with `inst_req` = 1; all valids 0 and `stallreq_from_if` = 1. Release reset; `arvalid` = 1 at cycle 1 with `araddr` = `inst_addr` and `arid` = 0.
- Single fetch, zero-wait slave, `inst_addr` = 0xBFC00000, `rdata` = 0x3C1D0001: `inst_data_ok` pulses at cycle 3 and `inst_rdata` = 0x3C1D0001.
- Simultaneous requests: load at 0x80001004 and fetch together. AR goes first with `arid` = 1 and the load address. The fetch AR follows only after the `data_data_ok` pulse. `stallreq_from_if` stays high throughout.
- Byte store, `data_size` = 0, `data_addr` = 0x80000003, `wdata` = 0xAAAAAAAA: `wstrb` = 4'b1000 and `awsize` = 0. With `wready` two cycles before `awready`, WR_RESP is entered only after both. `data_data_ok` pulses one cycle after `bvalid`.
- Back-to-back loads with `data_req` held: no duplicate AR during the `data_ok` cycle. The second load's `arvalid` rises exactly once after the pipeline presents the new address.
- Reset during RD_DATA: `rready` drops the next cycle, no `data_ok` pulse, state returns to IDLE.
